// File: rtl/data_mem_if.sv
// Data-memory request/response bus between the CPU MEM stage (master) and the responder (slave).
interface data_mem_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] address;
  logic [63:0] wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        err;
  logic        stall;

  modport master (output req_valid, req_write, req_size, address, wdata,
                  input  req_ready, resp_valid, rdata, err, stall);
  modport slave  (input  req_valid, req_write, req_size, address, wdata,
                  output req_ready, resp_valid, rdata, err, stall);
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency byte-addressed data memory for the CPU MEM stage, little-endian, with stall.
// DMEM_PERF_CNT_EN adds a saturating stall_cycles counter port.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  data_mem_if.slave   bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   accept, enter_done;
  logic                   op_write, op_err;
  logic [1:0]             op_size;
  logic [ADDR_WIDTH-1:0]  op_base;
  logic [63:0]            op_wdata;
  logic                   cur_write, cur_err, req_err;
  logic [1:0]             cur_size;
  logic [ADDR_WIDTH-1:0]  cur_base;
  logic [63:0]            cur_wdata, rd_word, rdata_q;
  logic [3:0]             nbytes;
  logic [2:0]             size_mask;
  logic                   err_q, stall_w;
  logic [7:0]             mem [DEPTH];

  always_comb begin
    case (bus.req_size)
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  end

  assign req_err = (|(bus.address[2:0] & size_mask)) | (|bus.address[63:ADDR_WIDTH]);

  // The live bus is the operand on the accept edge (LATENCY==1 commits right there);
  // afterwards the latched copy is used, since the bus is ignored outside IDLE.
  assign cur_write = (state == IDLE) ? bus.req_write                     : op_write;
  assign cur_size  = (state == IDLE) ? bus.req_size                      : op_size;
  assign cur_base  = (state == IDLE) ? bus.address[ADDR_WIDTH-1:0]       : op_base;
  assign cur_wdata = (state == IDLE) ? bus.wdata                         : op_wdata;
  assign cur_err   = (state == IDLE) ? req_err                           : op_err;
  assign nbytes    = 4'd1 << cur_size;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: if (bus.req_valid && !reset) begin
        accept = 1'b1;
        if (LATENCY == 1) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(LATENCY - 2);
        end
      end
      BUSY: if (cnt == 4'd0) begin
        state_nxt  = DONE;
        enter_done = !reset;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++)
      if (4'(i) < nbytes) rd_word[8*i +: 8] = mem[cur_base + ADDR_WIDTH'(i)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      op_size  <= '0;
      op_base  <= '0;
      op_wdata <= '0;
      op_err   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_write <= bus.req_write;
        op_size  <= bus.req_size;
        op_base  <= bus.address[ADDR_WIDTH-1:0];
        op_wdata <= bus.wdata;
        op_err   <= req_err;
      end
      // Only the edge entering DONE loads these, so they read as zero elsewhere.
      rdata_q <= (enter_done && !cur_write && !cur_err) ? rd_word : '0;
      err_q   <= enter_done && cur_err;
    end
  end

  // Storage deliberately has no reset; enter_done is already masked by reset.
  always_ff @(posedge clk) begin
    if (enter_done && cur_write && !cur_err)
      for (int i = 0; i < 8; i++)
        if (4'(i) < nbytes) mem[cur_base + ADDR_WIDTH'(i)] <= cur_wdata[8*i +: 8];
  end

  assign stall_w        = !reset && ((state == IDLE && bus.req_valid) || state == BUSY);
  assign bus.stall      = stall_w;
  assign bus.req_ready  = !reset && (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  stall_cycles <= '0;
    else if (stall_w && stall_cycles != '1)     stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized + directed bench for data_mem_responder against a byte-array memory model.
module tb_data_mem_responder;
  localparam int AW    = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_if bus ();
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
`ifdef DMEM_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mm [DEPTH];

  function automatic logic m_err(input logic [1:0] sz, input logic [63:0] a);
    longint unsigned n = 64'd1 << sz;
    return ((a % n) != 0) || (a >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] m_read(input logic [1:0] sz, input logic [63:0] a);
    logic [63:0] r = '0;
    for (int i = 0; i < (1 << sz); i++) r = r | (64'(mm[int'(a[AW-1:0]) + i]) << (8 * i));
    return r;
  endfunction

  task automatic m_write(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < (1 << sz); i++) mm[int'(a[AW-1:0]) + i] = d[8*i +: 8];
  endtask

  // One transaction; returns at the falling edge inside the response cycle.
  // lat counts rising edges from the accept edge (inclusive) to the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] rd, output logic e,
                        output int lat, output int stl);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.address = a; bus.wdata = d;
    rd = '0; e = 1'b0; lat = 0; stl = 0;
    #1 if (bus.stall === 1'b1) stl++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) stl++;
      if (bus.resp_valid === 1'b1) begin
        lat = i; rd = bus.rdata; e = bus.err;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.address = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.stall, bus.resp_valid, bus.err} !== 4'b0000 || bus.rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy/stall/rv/err=%b rdata=%h want 0000 0", {bus.req_ready, bus.stall, bus.resp_valid, bus.err}, bus.rdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.stall, bus.resp_valid} !== 3'b100) begin
        errors++;
        $display("FAIL idle_cycle%0d got rdy/stall/rv=%b want 100", i, {bus.req_ready, bus.stall, bus.resp_valid});
      end
    end
  endtask

  task automatic test_fill();
    logic [63:0] rd, d; logic e; int lat, stl;
    for (int a = 0; a < DEPTH; a += 8) begin
      d = {$urandom, $urandom};
      do_req(1'b1, 2'd3, 64'(a), d, rd, e, lat, stl);
      m_write(2'd3, 64'(a), d);
      checks++;
      if (e !== 1'b0 || lat != LAT) begin
        errors++;
        $display("FAIL fill addr=%0h got err=%b lat=%0d want 0 %0d", a, e, lat, LAT);
      end
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic e; int lat, stl;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] base = stall_cycles;
`endif
    do_req(1'b1, 2'd3, 64'h10, 64'h0123456789ABCDEF, rd, e, lat, stl);
    m_write(2'd3, 64'h10, 64'h0123456789ABCDEF);
    checks++;
    if (lat != LAT || stl != LAT || e !== 1'b0) begin
      errors++; $display("FAIL store_dword got lat=%0d stall=%0d err=%b want %0d %0d 0", lat, stl, e, LAT, LAT);
    end
    do_req(1'b0, 2'd3, 64'h10, 64'h0, rd, e, lat, stl);
    checks++;
    if (lat != LAT || stl != LAT) begin
      errors++; $display("FAIL load_timing got lat=%0d stall=%0d want %0d %0d", lat, stl, LAT, LAT);
    end
    checks++;
    if (rd !== 64'h0123456789ABCDEF || e !== 1'b0) begin
      errors++; $display("FAIL load_dword got %h err=%b want 0123456789abcdef 0", rd, e);
    end
`ifdef DMEM_PERF_CNT_EN
    checks++;
    if (stall_cycles - base !== 32'd6) begin
      errors++; $display("FAIL stall_cycles got +%0d want +6", stall_cycles - base);
    end
`endif
  endtask

  task automatic test_byte_merge();
    logic [63:0] rd; logic e; int lat, stl;
    do_req(1'b1, 2'd0, 64'h13, 64'hAA, rd, e, lat, stl);
    m_write(2'd0, 64'h13, 64'hAA);
    do_req(1'b0, 2'd3, 64'h10, 64'h0, rd, e, lat, stl);
    checks++;
    if (rd !== 64'h01234567AAABCDEF || e !== 1'b0) begin
      errors++; $display("FAIL merge_dword got %h err=%b want 01234567aaabcdef 0", rd, e);
    end
    do_req(1'b0, 2'd0, 64'h13, 64'h0, rd, e, lat, stl);
    checks++;
    if (rd !== 64'h00000000000000AA || e !== 1'b0) begin
      errors++; $display("FAIL load_byte got %h err=%b want aa 0", rd, e);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic e; int lat, stl;
    do_req(1'b0, 2'd3, 64'h14, 64'h0, rd, e, lat, stl);
    checks++;
    if (e !== 1'b1 || rd !== 64'd0 || lat != LAT) begin
      errors++; $display("FAIL misalign_load got err=%b rdata=%h lat=%0d want 1 0 %0d", e, rd, lat, LAT);
    end
    do_req(1'b1, 2'd3, 64'h14, 64'hDEADBEEFCAFEF00D, rd, e, lat, stl);
    checks++;
    if (e !== 1'b1 || lat != LAT) begin
      errors++; $display("FAIL misalign_store got err=%b lat=%0d want 1 %0d", e, lat, LAT);
    end
    do_req(1'b0, 2'd3, 64'h10, 64'h0, rd, e, lat, stl);
    checks++;
    if (rd !== 64'h01234567AAABCDEF || e !== 1'b0) begin
      errors++; $display("FAIL after_err_store got %h want 01234567aaabcdef", rd);
    end
    do_req(1'b0, 2'd3, 64'h400, 64'h0, rd, e, lat, stl);
    checks++;
    if (e !== 1'b1 || rd !== 64'd0 || lat != LAT) begin
      errors++; $display("FAIL out_of_range got err=%b rdata=%h lat=%0d want 1 0 %0d", e, rd, lat, LAT);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] rd; logic e; int lat, stl;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd3; bus.address = 64'h20; bus.wdata = 64'hFF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.stall, bus.resp_valid} !== 3'b000) begin
      errors++; $display("FAIL midop_reset got rdy/stall/rv=%b want 000", {bus.req_ready, bus.stall, bus.resp_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL post_reset%0d got rv=%b rdy=%b want 0 1", i, bus.resp_valid, bus.req_ready);
      end
    end
    do_req(1'b0, 2'd3, 64'h20, 64'h0, rd, e, lat, stl);
    checks++;
    if (rd !== m_read(2'd3, 64'h20) || e !== 1'b0) begin
      errors++; $display("FAIL aborted_store got %h want %h", rd, m_read(2'd3, 64'h20));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic e; int lat, stl;
    do_req(1'b0, 2'd2, 64'h8, 64'h0, rd, e, lat, stl);
    bus.req_valid = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL done_cycle got rdy=%b stall=%b want 0 0", bus.req_ready, bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.stall !== 1'b1) begin
      errors++; $display("FAIL bubble_idle got rdy=%b stall=%b want 1 1", bus.req_ready, bus.stall);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] rd, a, d, exp_rd; logic e, exp_e, w; logic [1:0] sz; int lat, stl, kind;
    for (int n = 0; n < 200; n++) begin
      sz   = 2'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      d    = {$urandom, $urandom};
      kind = $urandom_range(0, 9);
      if (kind < 8)      a = 64'($urandom_range(0, DEPTH - 1)) & ~((64'd1 << sz) - 64'd1);
      else if (kind < 9) a = 64'($urandom_range(0, DEPTH - 1)) | 64'd1;
      else               a = {$urandom, $urandom} | 64'(DEPTH);
      exp_e  = m_err(sz, a);
      exp_rd = (w || exp_e) ? 64'd0 : m_read(sz, a);
      do_req(w, sz, a, d, rd, e, lat, stl);
      if (w && !exp_e) m_write(sz, a, d);
      checks++;
      if (e !== exp_e || lat != LAT || stl != LAT || (!w && rd !== exp_rd)) begin
        errors++;
        $display("FAIL random%0d w=%b sz=%0d a=%h got err=%b rd=%h lat=%0d stl=%0d want %b %h %0d %0d",
                 n, w, sz, a, e, rd, lat, stl, exp_e, exp_rd, LAT, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_byte_merge();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
